// File: rtl/fpu_stream_pipe.sv
// fpu_stream_pipe: streaming valid/ready wrapper around the combinational
// single-precision FPU_unit adder/subtractor.
//
// Ports:
//   i_clk, i_rst_n            clock, asynchronous active-low reset
//   i_flush                   synchronous discard of everything in flight
//   i_valid/o_ready           operand handshake (i_fpu_op, i_floating_a/b, i_tag)
//   o_valid/i_ready           result handshake (o_floating_result, o_tag)
//   o_inflight                operations accepted and not yet popped
//
// FPU_unit (same file): IEEE-754 single add (op=0) / sub (op=1),
// round-to-nearest-even, subnormal inputs/outputs flushed to zero,
// exponent overflow returns signed infinity.

module FPU_unit #(
    parameter int NUM_OP = 1
) (
    input  logic [NUM_OP-1:0] i_fpu_op,
    input  logic [31:0]       i_floating_a,
    input  logic [31:0]       i_floating_b,
    output logic [31:0]       o_floating_result
);
    logic        sign_b, sign_l, sign_s, sticky, rup;
    logic [7:0]  exp_l;
    logic [23:0] man_a, man_b, man_l, man_s;
    logic [26:0] ext_l, ext_s, norm;
    logic [27:0] sum;
    logic [24:0] rnd;
    logic [22:0] frac;
    int          diff, e, lz;
    logic        found;

    always_comb begin
        sign_b = i_floating_b[31] ^ i_fpu_op[0];
        man_a  = (i_floating_a[30:23] == 8'd0) ? 24'd0 : {1'b1, i_floating_a[22:0]};
        man_b  = (i_floating_b[30:23] == 8'd0) ? 24'd0 : {1'b1, i_floating_b[22:0]};
        // Larger magnitude goes to the "l" side so the subtraction never goes negative.
        if (i_floating_b[30:0] > i_floating_a[30:0]) begin
            sign_l = sign_b;          exp_l = i_floating_b[30:23]; man_l = man_b;
            sign_s = i_floating_a[31]; man_s = man_a;
            diff   = int'(i_floating_b[30:23]) - int'(i_floating_a[30:23]);
        end else begin
            sign_l = i_floating_a[31]; exp_l = i_floating_a[30:23]; man_l = man_a;
            sign_s = sign_b;          man_s = man_b;
            diff   = int'(i_floating_a[30:23]) - int'(i_floating_b[30:23]);
        end
        // Three extra bits below the LSB: guard, round, sticky.
        ext_l  = {man_l, 3'b000};
        ext_s  = {man_s, 3'b000};
        sticky = 1'b0;
        for (int i = 0; i < 27; i++)
            if (i < diff && ext_s[i]) sticky = 1'b1;
        ext_s    = (diff >= 27) ? 27'd0 : (ext_s >> diff);
        ext_s[0] = ext_s[0] | sticky;

        sum = (sign_l == sign_s) ? ({1'b0, ext_l} + {1'b0, ext_s})
                                 : ({1'b0, ext_l} - {1'b0, ext_s});
        e     = int'(exp_l);
        lz    = 0;
        found = 1'b0;
        if (sum[27]) begin
            norm    = sum[27:1];
            norm[0] = sum[1] | sum[0];
            e       = e + 1;
        end else begin
            norm = sum[26:0];
            for (int i = 26; i >= 0; i--) begin
                if (!found) begin
                    if (norm[i]) found = 1'b1;
                    else         lz    = lz + 1;
                end
            end
            norm = norm << lz;
            e    = e - lz;
        end

        rup = norm[2] & (norm[1] | norm[0] | norm[3]);
        rnd = {1'b0, norm[26:3]} + {24'd0, rup};
        if (rnd[24]) begin
            frac = rnd[23:1];
            e    = e + 1;
        end else begin
            frac = rnd[22:0];
        end

        if (sum == 28'd0 || exp_l == 8'd0)
            o_floating_result = 32'd0;
        else if (e >= 255)
            o_floating_result = {sign_l, 8'hFF, 23'd0};
        else if (e <= 0)
            o_floating_result = {sign_l, 31'd0};
        else
            o_floating_result = {sign_l, e[7:0], frac};
    end
endmodule

module fpu_stream_pipe #(
    parameter int NUM_OP      = 1,
    parameter int PIPE_STAGES = 2,
    parameter int FIFO_DEPTH  = 8,
    parameter int TAG_W       = 4
) (
    input  logic                            i_clk,
    input  logic                            i_rst_n,
    input  logic                            i_flush,
    input  logic                            i_valid,
    output logic                            o_ready,
    input  logic [NUM_OP-1:0]               i_fpu_op,
    input  logic [31:0]                     i_floating_a,
    input  logic [31:0]                     i_floating_b,
    input  logic [TAG_W-1:0]                i_tag,
    output logic                            o_valid,
    input  logic                            i_ready,
    output logic [31:0]                     o_floating_result,
    output logic [TAG_W-1:0]                o_tag,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] o_inflight
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH+1);

    logic                   vld_p0;
    logic [NUM_OP-1:0]      op_p0;
    logic [31:0]            a_p0, b_p0, fpu_res;
    logic [TAG_W-1:0]       tag_p0;
    logic [PIPE_STAGES:1]   vld_p;
    logic [31:0]            res_p [1:PIPE_STAGES];
    logic [TAG_W-1:0]       tag_p [1:PIPE_STAGES];
    logic [31:0]            mem_res [FIFO_DEPTH];
    logic [TAG_W-1:0]       mem_tag [FIFO_DEPTH];
    logic [AW:0]            wptr, rptr;
    logic [CW-1:0]          cnt;
    logic                   fifo_empty, fifo_full, accept, pop;

    // Pointers carry one wrap bit so full and empty are distinguishable.
    assign fifo_empty = (wptr == rptr);
    assign fifo_full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    // Credits cover the whole pipeline, so a granted op always finds a FIFO slot.
    assign o_ready    = ~i_flush & (cnt < CW'(FIFO_DEPTH));
    assign o_valid    = ~i_flush & ~fifo_empty;
    assign accept     = i_valid & o_ready;
    assign pop        = o_valid & i_ready;
    assign o_inflight = cnt;
    assign o_floating_result = fifo_empty ? 32'd0 : mem_res[rptr[AW-1:0]];
    assign o_tag             = fifo_empty ? '0    : mem_tag[rptr[AW-1:0]];

    // Stage 0: input register feeding the core
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            vld_p0 <= 1'b0;
            op_p0  <= '0;
            a_p0   <= 32'd0;
            b_p0   <= 32'd0;
            tag_p0 <= '0;
        end else begin
            vld_p0 <= accept;
            if (accept) begin
                op_p0  <= i_fpu_op;
                a_p0   <= i_floating_a;
                b_p0   <= i_floating_b;
                tag_p0 <= i_tag;
            end
        end
    end

    FPU_unit #(.NUM_OP(NUM_OP)) u_fpu (
        .i_fpu_op         (op_p0),
        .i_floating_a     (a_p0),
        .i_floating_b     (b_p0),
        .o_floating_result(fpu_res)
    );

    // Stages 1..PIPE_STAGES: free-running retiming, never stalled
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            vld_p <= '0;
            for (int i = 1; i <= PIPE_STAGES; i++) begin
                res_p[i] <= 32'd0;
                tag_p[i] <= '0;
            end
        end else begin
            vld_p[1] <= vld_p0 & ~i_flush;
            res_p[1] <= fpu_res;
            tag_p[1] <= tag_p0;
            for (int i = 2; i <= PIPE_STAGES; i++) begin
                vld_p[i] <= vld_p[i-1] & ~i_flush;
                res_p[i] <= res_p[i-1];
                tag_p[i] <= tag_p[i-1];
            end
        end
    end

    // Output FIFO and credit counter
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_res[i] <= 32'd0;
                mem_tag[i] <= '0;
            end
        end else if (i_flush) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (vld_p[PIPE_STAGES]) begin
                mem_res[wptr[AW-1:0]] <= res_p[PIPE_STAGES];
                mem_tag[wptr[AW-1:0]] <= tag_p[PIPE_STAGES];
                wptr <= wptr + 1'b1;
            end
            if (pop) rptr <= rptr + 1'b1;
            if (accept && !pop)      cnt <= cnt + 1'b1;
            else if (pop && !accept) cnt <= cnt - 1'b1;
        end
    end

    a_no_overflow: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        (vld_p[PIPE_STAGES] && !i_flush) |-> !fifo_full);
endmodule

// File: tb/tb_fpu_stream_pipe.sv
module tb_fpu_stream_pipe;
    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_flush = 1'b0;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic [0:0]  i_fpu_op = 1'b0;
    logic [31:0] i_floating_a = 32'd0;
    logic [31:0] i_floating_b = 32'd0;
    logic [3:0]  i_tag = 4'd0;
    logic        o_valid;
    logic        i_ready = 1'b0;
    logic [31:0] o_floating_result;
    logic [3:0]  o_tag;
    logic [3:0]  o_inflight;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] q_res[$];
    logic [3:0]  q_tag[$];

    typedef struct {
        logic        op;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  tag;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs[12];

    fpu_stream_pipe dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_flush(i_flush),
        .i_valid(i_valid), .o_ready(o_ready), .i_fpu_op(i_fpu_op),
        .i_floating_a(i_floating_a), .i_floating_b(i_floating_b), .i_tag(i_tag),
        .o_valid(o_valid), .i_ready(i_ready), .o_floating_result(o_floating_result),
        .o_tag(o_tag), .o_inflight(o_inflight)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Exact int -> float for |v| < 2^24.
    function automatic logic [31:0] int2f(input int v);
        logic s; int m; int p; logic [31:0] mm;
        if (v == 0) return 32'd0;
        s = (v < 0);
        m = s ? -v : v;
        p = 0;
        for (int i = 0; i < 24; i++) if (m[i]) p = i;
        mm = 32'(m) << (23 - p);
        return {s, 8'(127 + p), mm[22:0]};
    endfunction

    task automatic step();
        @(posedge i_clk); #1;
    endtask

    task automatic drive(input logic op, input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag);
        i_fpu_op = op; i_floating_a = a; i_floating_b = b; i_tag = tag;
    endtask

    // Random integer-valued op, expected value pushed to the scoreboard.
    task automatic drive_rand(input logic [3:0] tag);
        int x, y; logic op;
        x  = int'($urandom_range(2000, 0)) - 1000;
        y  = int'($urandom_range(2000, 0)) - 1000;
        op = 1'($urandom_range(1, 0));
        drive(op, int2f(x), int2f(y), tag);
        q_res.push_back(int2f(op ? x - y : x + y));
        q_tag.push_back(tag);
    endtask

    task automatic check_head(input string nm);
        logic [31:0] er; logic [3:0] et;
        er = q_res.pop_front();
        et = q_tag.pop_front();
        check({nm, "_res"}, o_floating_result, er);
        check({nm, "_tag"}, 32'(o_tag), 32'(et));
    endtask

    // Single op from an idle pipe with full latency and inflight tracking.
    task automatic latency_op(input string nm, input logic op, input logic [31:0] a,
                              input logic [31:0] b, input logic [3:0] tag, input logic [31:0] exp);
        check({nm, "_rdy"}, 32'(o_ready), 32'd1);
        drive(op, a, b, tag);
        i_valid = 1'b1;
        step();                         // edge k
        i_valid = 1'b0;
        check({nm, "_inf_k"}, 32'(o_inflight), 32'd1);
        for (int c = 1; c <= 2; c++) begin
            step();
            check({nm, "_vld_early"}, 32'(o_valid), 32'd0);
            check({nm, "_inf"}, 32'(o_inflight), 32'd1);
        end
        step();                         // edge k+3
        check({nm, "_vld"}, 32'(o_valid), 32'd1);
        check({nm, "_res"}, o_floating_result, exp);
        check({nm, "_tag"}, 32'(o_tag), 32'(tag));
        check({nm, "_inf_k3"}, 32'(o_inflight), 32'd1);
        i_ready = 1'b1;
        step();                         // edge k+4: pop
        i_ready = 1'b0;
        check({nm, "_inf_pop"}, 32'(o_inflight), 32'd0);
        check({nm, "_vld_pop"}, 32'(o_valid), 32'd0);
    endtask

    initial begin
        int accepts, ready_low, sent, recv, t, stale;

        vecs[0]  = '{1'b0, 32'h3F800000, 32'h40000000, 4'h5, 32'h40400000}; // 1+2
        vecs[1]  = '{1'b1, 32'h40400000, 32'h3F800000, 4'h1, 32'h40000000}; // 3-1
        vecs[2]  = '{1'b1, 32'h3F800000, 32'h3F800000, 4'h2, 32'h00000000}; // 1-1
        vecs[3]  = '{1'b0, 32'h3FC00000, 32'h3E800000, 4'h3, 32'h3FE00000}; // 1.5+0.25
        vecs[4]  = '{1'b1, 32'h40A00000, 32'h41200000, 4'h4, 32'hC0A00000}; // 5-10
        vecs[5]  = '{1'b0, 32'hC0000000, 32'hC0400000, 4'h6, 32'hC0A00000}; // -2+-3
        vecs[6]  = '{1'b0, 32'h3F800000, 32'h33800000, 4'h7, 32'h3F800000}; // tie, even
        vecs[7]  = '{1'b0, 32'h3F800001, 32'h33800000, 4'h8, 32'h3F800002}; // tie, odd up
        vecs[8]  = '{1'b0, 32'h3F800000, 32'h33C00000, 4'h9, 32'h3F800001}; // above half
        vecs[9]  = '{1'b0, 32'h7F7FFFFF, 32'h7F7FFFFF, 4'hA, 32'h7F800000}; // overflow
        vecs[10] = '{1'b0, 32'h3F800000, 32'h00000000, 4'hB, 32'h3F800000}; // x+0
        vecs[11] = '{1'b0, 32'h4B7FFFFF, 32'h3F800000, 4'hC, 32'h4B800000}; // carry out

        // Reset values
        #12;
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_ready", 32'(o_ready), 32'd1);
        check("rst_inflight", 32'(o_inflight), 32'd0);
        check("rst_result", o_floating_result, 32'd0);
        check("rst_tag", 32'(o_tag), 32'd0);
        @(negedge i_clk); i_rst_n = 1'b1;
        step();

        // Table of single ops (entry 0 is the 1.0+2.0 single-op case)
        for (int v = 0; v < 12; v++)
            latency_op($sformatf("vec%0d", v), vecs[v].op, vecs[v].a, vecs[v].b, vecs[v].tag, vecs[v].exp);

        // Streaming: 100 back-to-back ops, i_ready held high
        i_ready = 1'b1; ready_low = 0; sent = 0; recv = 0; t = 0;
        while (recv < 100 && t < 400) begin
            if (o_valid) begin
                if (q_res.size() > 0) check_head($sformatf("stream%0d", recv));
                else check("stream_extra", 32'd1, 32'd0);
                recv++;
            end
            if (sent < 100) begin
                if (o_ready) begin drive_rand(4'(sent)); sent++; end
                else ready_low++;
                i_valid = (sent <= 100) && o_ready;
            end else i_valid = 1'b0;
            step(); t++;
        end
        i_valid = 1'b0;
        check("stream_count", 32'(recv), 32'd100);
        check("stream_ready_low", 32'(ready_low), 32'd0);
        check("stream_inflight", 32'(o_inflight), 32'd0);
        i_ready = 1'b0;
        q_res.delete(); q_tag.delete();

        // Backpressure: fill to 8 credits
        accepts = 0;
        drive_rand(4'(0));
        i_valid = 1'b1;
        for (int c = 0; c < 14; c++) begin
            if (o_ready) accepts++;
            step();
            if (accepts > 0 && accepts < 8 && o_ready) drive_rand(4'(accepts));
        end
        i_valid = 1'b0;
        while (q_res.size() > accepts) begin void'(q_res.pop_back()); void'(q_tag.pop_back()); end
        check("bp_accepts", 32'(accepts), 32'd8);
        check("bp_ready", 32'(o_ready), 32'd0);
        check("bp_inflight", 32'(o_inflight), 32'd8);
        check("bp_valid", 32'(o_valid), 32'd1);
        i_ready = 1'b1;
        check_head("bp0");
        step();
        check("bp_ready_after_pop", 32'(o_ready), 32'd1);
        check("bp_inflight_after_pop", 32'(o_inflight), 32'd7);
        t = 0;
        while (q_res.size() > 0 && t < 30) begin
            if (o_valid) check_head("bp");
            step(); t++;
        end
        check("bp_drain_left", 32'(q_res.size()), 32'd0);
        check("bp_empty", 32'(o_valid), 32'd0);
        i_ready = 1'b0;

        // Simultaneous accept and pop at inflight 7
        for (int c = 0; c < 7; c++) begin
            drive_rand(4'(c + 8)); i_valid = 1'b1; step();
        end
        i_valid = 1'b0;
        repeat (5) step();
        check("sim_inflight7", 32'(o_inflight), 32'd7);
        check_head("sim_first");
        drive_rand(4'hF); i_valid = 1'b1; i_ready = 1'b1;
        step();
        i_valid = 1'b0;
        check("sim_inflight_hold", 32'(o_inflight), 32'd7);
        check("sim_ready_hold", 32'(o_ready), 32'd1);
        t = 0; recv = 1;
        while (q_res.size() > 0 && t < 30) begin
            if (o_valid) begin check_head("sim"); recv++; end
            step(); t++;
        end
        check("sim_recv", 32'(recv), 32'd8);
        check("sim_empty", 32'(o_valid), 32'd0);
        check("sim_inflight0", 32'(o_inflight), 32'd0);
        i_ready = 1'b0;

        // Flush with 5 ops in flight (2 in FIFO, 3 in the pipe)
        for (int c = 0; c < 5; c++) begin
            drive_rand(4'(c)); i_valid = 1'b1; step();
        end
        i_valid = 1'b0;
        check("fl_pre_valid", 32'(o_valid), 32'd1);
        i_flush = 1'b1; #1;
        check("fl_ready_during", 32'(o_ready), 32'd0);
        check("fl_valid_during", 32'(o_valid), 32'd0);
        step();
        i_flush = 1'b0; #1;
        check("fl_valid", 32'(o_valid), 32'd0);
        check("fl_inflight", 32'(o_inflight), 32'd0);
        check("fl_ready", 32'(o_ready), 32'd1);
        stale = 0;
        repeat (6) begin step(); if (o_valid) stale++; end
        check("fl_stale", 32'(stale), 32'd0);
        q_res.delete(); q_tag.delete();
        latency_op("fl_new", 1'b0, 32'h40400000, 32'h40A00000, 4'h9, 32'h41000000); // 3+5

        // Reset mid-stream with 6 ops in flight
        for (int c = 0; c < 6; c++) begin
            drive_rand(4'(c)); i_valid = 1'b1; step();
        end
        i_valid = 1'b0;
        check("rs_pre_valid", 32'(o_valid), 32'd1);
        #2 i_rst_n = 1'b0;
        #1;
        check("rs_valid", 32'(o_valid), 32'd0);
        check("rs_inflight", 32'(o_inflight), 32'd0);
        check("rs_ready", 32'(o_ready), 32'd1);
        check("rs_result", o_floating_result, 32'd0);
        check("rs_tag", 32'(o_tag), 32'd0);
        @(posedge i_clk); @(negedge i_clk); i_rst_n = 1'b1;
        step();
        stale = 0;
        repeat (6) begin if (o_valid) stale++; step(); end
        check("rs_stale", 32'(stale), 32'd0);
        q_res.delete(); q_tag.delete();
        latency_op("rs_new", 1'b1, 32'h41200000, 32'h40400000, 4'h3, 32'h40E00000); // 10-3

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fpu_stream_pipe.md
# fpu_stream_pipe

Streaming wrapper around the combinational `FPU_unit` core. It accepts single-precision operand pairs on a valid/ready interface and runs them through a configurable number of retiming stages. Results land in an output FIFO, so downstream backpressure never stalls the arithmetic pipeline. It replaces the fixed 2-register wrapper wherever the core sits behind a bus or a producer that needs flow control, tagging or flush.

## Interface
- `NUM_OP`, default 1: width of the opcode passed to `FPU_unit`.
- `PIPE_STAGES`, default 2: register stages after `FPU_unit`; must be ≥1.
- `FIFO_DEPTH`, default 8: output FIFO entries.
  - Must be a power of 2, ≥2.
  - Full throughput requires `FIFO_DEPTH ≥ PIPE_STAGES+3`.
- `TAG_W`, default 4: width of the sideband tag carried alongside each operation.
- `i_clk`, in, 1: clock. All state updates on the rising edge.
- `i_rst_n`, in, 1: asynchronous, active-low reset.
- `i_flush`, in, 1: synchronous flush. Discards everything in flight and in the FIFO.
- `i_valid`, in, 1: operand pair valid.
- `o_ready`, out, 1: block can accept an operand pair.
- `i_fpu_op`, in, NUM_OP: opcode to `FPU_unit`.
  - 0 = add, 1 = sub.
- `i_floating_a`, in, 32: IEEE-754 single operand A.
- `i_floating_b`, in, 32: IEEE-754 single operand B.
- `i_tag`, in, TAG_W: tag, returned unchanged with the result.
- `o_valid`, out, 1: result at FIFO head is valid.
- `i_ready`, in, 1: downstream accepts the result.
- `o_floating_result`, out, 32: result at the FIFO head.
- `o_tag`, out, TAG_W: tag of the head result.
- `o_inflight`, out, $clog2(FIFO_DEPTH+1): operations accepted and not yet popped.

## Operation
**Handshakes**
- Accept: `i_valid & o_ready` at a rising edge.
- Pop: `o_valid & i_ready` at a rising edge.

**Datapath**
- Stage 0 is the input register, capturing op, a, b, tag and a valid bit on accept.
- Stage 0 drives `FPU_unit`.
- Stages 1..PIPE_STAGES carry result, tag and valid. They shift every cycle and never stall.
- When stage PIPE_STAGES holds valid data, the FIFO write pointer increments (wraps modulo FIFO_DEPTH).

**Credit counter `cnt` (0..FIFO_DEPTH)**
- +1 on accept, −1 on pop, unchanged when both or neither occur.
- `o_inflight = cnt`.

**Ready, valid and output data**
- `o_ready = ~i_flush & (cnt < FIFO_DEPTH)`.
- `o_ready` has no combinational path from `i_ready` or `i_valid`.
- `o_valid = ~i_flush & ~fifo_empty`.
- `o_floating_result` and `o_tag` show the FIFO head when non-empty, and 0 when empty.

**Overflow guarantee**
- The credit rule guarantees the FIFO never overflows. A write while the FIFO is full is a design error and is covered by an assertion.

**Ordering**
- Results leave strictly in acceptance order.
- The tag is not interpreted.

**Flush** (`i_flush`=1 at an edge)
- Clears all stage valid bits, both FIFO pointers and `cnt`.
- No accept or pop occurs in that cycle.
- Stage data registers keep their values; they are don't-care.

## Timing
**Reset values** (while `i_rst_n`=0)
- Asynchronous clear of all valids, pointers and `cnt`.
- Data registers are 0.
- `o_valid`=0, `o_floating_result`=0, `o_tag`=0, `o_inflight`=0.
- `o_ready`=1, because it is derived from `cnt`=0.

**Latency**
- Accept at edge k → written to FIFO at edge k+PIPE_STAGES+1 → `o_valid`=1 in the cycle after that edge.
- Latency is PIPE_STAGES+1 edges; the default gives 3.
- Earliest pop is at edge k+PIPE_STAGES+2.

**Throughput**
- One operation per cycle while `i_ready`=1 and FIFO_DEPTH ≥ PIPE_STAGES+3.
- Otherwise `o_ready` drops periodically.

**Boundary conditions**
- Full, `cnt`=FIFO_DEPTH: `o_ready`=0.
  - A pop at edge e raises `o_ready` in the cycle after e.
- Simultaneous accept and pop at `cnt`=FIFO_DEPTH−1: `cnt` stays at FIFO_DEPTH−1 and `o_ready` stays 1.
- FIFO empty with `i_ready`=1: no pop and `cnt` unchanged.
- FIFO pointers wrap from FIFO_DEPTH−1 to 0 without a bubble.
- Reset mid-operation: all in-flight results are lost, with no partial output after release.

## Test plan
- **Single op:** accept op=0, a=0x3F800000, b=0x40000000, tag=0x5 at edge k (defaults).
  - `o_valid` rises after edge k+3.
  - `o_floating_result`=0x40400000 and `o_tag`=0x5.
  - Pop at edge k+4; `o_inflight` sequence 1,1,1,1,0.
- **Streaming:** FIFO_DEPTH=8, PIPE_STAGES=2, `i_ready`=1, 100 back-to-back random add/sub ops.
  - `o_ready` never low.
  - Results match a reference model, in order, with tags 0..15 repeating.
- **Backpressure:** `i_ready`=0, continuous `i_valid`.
  - Exactly 8 accepts occur, then `o_ready`=0 and `o_inflight`=8.
  - Raise `i_ready`: 8 results drain in order, and `o_ready` returns 1 the cycle after the first pop.
- **Simultaneous accept/pop:** at `o_inflight`=7, accept and pop in the same edge.
  - `o_inflight` stays 7 and no result is lost or duplicated.
- **Flush:** with 5 ops in flight, pulse `i_flush` for one cycle.
  - Next cycle: `o_valid`=0 and `o_inflight`=0.
  - A new op accepted afterwards returns with correct latency and only its own result appears.
- **Reset mid-stream:** assert `i_rst_n`=0 asynchronously with 6 ops in flight.
  - Outputs go immediately to their reset values.
  - After release, no stale `o_valid`; a subsequent op completes normally.
